mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 23 ++
 rtl/mem_responder_if.sv | 31 +++
 rtl/mem_rsp_pipe.sv | 33 +++
 rtl/mem_responder.sv | 120 ++++++++++++
 tb/tb_mem_responder.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg -- shared definitions for the mem_responder slice.
//   state_e         : burst sequencer states (ST_IDLE, ST_BURST)
//   BLOCK_WORDS     : words per burst block
//   LATENCY_DEFAULT : default acceptance-to-response latency in cycles
//   rsp_beat_t      : one response beat as carried down the response pipe
package mem_responder_pkg;

  localparam int LATENCY_DEFAULT = 4;
  localparam int BLOCK_WORDS     = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  typedef struct packed {
    logic        valid;
    logic [15:0] addr;  // word-aligned byte address
    logic [2:0]  word;  // beat index inside a burst, 0 for single reads
    logic [15:0] data;
  } rsp_beat_t;

endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if -- request/response bus of the memory responder.
//   req_en/req_wr/req_burst : request strobe, write select, block-read select
//   req_addr/req_wdata      : byte address (bit 0 ignored), write data
//   req_ready               : request accepted this cycle when high with req_en
//   rsp_valid/rsp_data      : read response strobe and data
//   rsp_addr/rsp_word       : byte address and burst beat of rsp_data
// master drives requests, slave (the responder) drives ready and responses.
interface mem_responder_if;

  logic        req_en;
  logic        req_wr;
  logic        req_burst;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic [15:0] rsp_addr;
  logic [2:0]  rsp_word;

  modport master (
    output req_en, req_wr, req_burst, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_word
  );

  modport slave (
    input  req_en, req_wr, req_burst, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_word
  );

endinterface

// File: rtl/mem_rsp_pipe.sv
// mem_rsp_pipe -- fixed-latency shift register for response beats.
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset, clears every stage
//   beat_i : beat issued this cycle (valid=0 when nothing issues)
//   beat_o : beat issued LATENCY cycles earlier
module mem_rsp_pipe
  import mem_responder_pkg::*;
#(
  parameter int LATENCY = LATENCY_DEFAULT
) (
  input  logic      clk,
  input  logic      rst,
  input  rsp_beat_t beat_i,
  output rsp_beat_t beat_o
);

  rsp_beat_t stage_q [LATENCY];

  // NOTE: sequential state uses non-blocking assignments so every stage
  // shifts from its neighbour's old value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // Whole stages clear, so the outputs read zero right after reset.
      for (int i = 0; i < LATENCY; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= beat_i;
      for (int i = 1; i < LATENCY; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign beat_o = stage_q[LATENCY-1];

endmodule

// File: rtl/mem_responder.sv
// mem_responder -- 16-bit word memory with fixed-latency read responses.
//   clk : rising-edge clock
//   rst : synchronous active-high reset (storage contents are kept)
//   bus : mem_responder_if.slave request/response bus
// Parameters: LATENCY (1..8) cycles from acceptance to rsp_valid,
//             DEPTH_W word-address width (2^DEPTH_W words, DEPTH_W <= 15).
// Optional feature: define MEM_RESPONDER_BURST_EN to add 8-word block reads
// (BURST state plus beat counter). Without it req_burst is ignored and every
// read is a single read.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int LATENCY = LATENCY_DEFAULT,
  parameter int DEPTH_W = 15
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);

  localparam int WORDS = 1 << DEPTH_W;

  logic [15:0] mem_q [WORDS];
  logic        accept;
  rsp_beat_t   issue;
  rsp_beat_t   rsp_q;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = bus.req_addr[0];

`ifdef MEM_RESPONDER_BURST_EN
  state_e      state_q, state_d;
  logic [2:0]  beat_q, beat_d;
  logic [11:0] base_q, base_d;  // block base, byte address bits [15:4]

  assign bus.req_ready = !rst && (state_q == ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
    end
  end
`else
  logic unused_burst;

  assign unused_burst  = bus.req_burst;
  assign bus.req_ready = !rst;
`endif

  assign accept = bus.req_en && bus.req_ready;

  // Issue stage: decides which word (if any) enters the response pipe this
  // cycle and samples storage for it before any write on the same edge.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the branches below can leave it unassigned and infer a latch.
    issue      = '0;
    issue.addr = {bus.req_addr[15:1], 1'b0};
`ifdef MEM_RESPONDER_BURST_EN
    state_d = state_q;
    beat_d  = beat_q;
    base_d  = base_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && !bus.req_wr) begin
          issue.valid = 1'b1;
          if (bus.req_burst) begin
            // Beat 0 issues on the acceptance cycle itself.
            issue.addr = {bus.req_addr[15:4], 4'b0};
            base_d     = bus.req_addr[15:4];
            beat_d     = 3'd1;
            state_d    = ST_BURST;
          end
        end
      end
      ST_BURST: begin
        issue.valid = 1'b1;
        issue.addr  = {base_q, beat_q, 1'b0};
        issue.word  = beat_q;
        beat_d      = beat_q + 3'd1;
        if (beat_q == 3'(BLOCK_WORDS - 1)) begin
          state_d = ST_IDLE;
          beat_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`else
    issue.valid = accept && !bus.req_wr;
`endif
    issue.data = mem_q[issue.addr[DEPTH_W:1]];
    // Idle slots travel as all-zero beats so the outputs stay quiet.
    if (!issue.valid) issue = '0;
  end

  // NOTE: storage is deliberately not reset; rst only flushes control and
  // the response pipe, and memory contents survive it.
  always_ff @(posedge clk) begin
    if (accept && bus.req_wr) mem_q[bus.req_addr[DEPTH_W:1]] <= bus.req_wdata;
  end

  mem_rsp_pipe #(.LATENCY(LATENCY)) u_pipe (
    .clk    (clk),
    .rst    (rst),
    .beat_i (issue),
    .beat_o (rsp_q)
  );

  assign bus.rsp_valid = rsp_q.valid;
  assign bus.rsp_addr  = rsp_q.addr;
  assign bus.rsp_word  = rsp_q.word;
  assign bus.rsp_data  = rsp_q.data;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder -- self-checking bench for mem_responder.
// A behavioural model keeps a word array and a per-cycle schedule of the
// responses that must appear; a compare process checks req_ready before each
// edge and the response outputs after each edge. Directed sequences pin the
// model with literal expectations, then randomized traffic (with occasional
// resets) runs against the model. Burst checks follow MEM_RESPONDER_BURST_EN.
module tb_mem_responder;

  localparam int LAT   = 4;
  localparam int DW    = 7;            // small storage so address wrap is exercised
  localparam int WORDS = 1 << DW;
`ifdef MEM_RESPONDER_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  mem_responder_if bus ();

  mem_responder #(.LATENCY(LAT), .DEPTH_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] mem_m [WORDS];
  bit          ev [64];
  logic [15:0] ea [64];
  logic [15:0] ed [64];
  logic [2:0]  ew [64];
  int          cyc        = 0;
  int          busy_until = -1;
  bit          armed      = 1'b0;
  bit          rst_prev   = 1'b0;
  int          slot;
  int          base;

  function automatic int widx(input int byte_addr);
    return (byte_addr / 2) % WORDS;
  endfunction

  task automatic sched(input int at, input int addr, input int word, input logic [15:0] data);
    ev[at % 64] = 1'b1;
    ea[at % 64] = 16'(addr);
    ew[at % 64] = 3'(word);
    ed[at % 64] = data;
  endtask

  // Compare process: model update from the inputs seen before each edge,
  // output comparison just after it.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (armed && !rst) check("req_ready", bus.req_ready, cyc > busy_until);
      if (rst) begin
        for (int i = 0; i < 64; i++) ev[i] = 1'b0;
        busy_until = -1;
        armed      = 1'b1;
      end else if (armed && bus.req_en && cyc > busy_until) begin
        if (bus.req_wr) begin
          mem_m[widx(bus.req_addr)] = bus.req_wdata;
        end else if (BURST_EN && bus.req_burst) begin
          base = (int'(bus.req_addr) / 16) * 16;
          for (int b = 0; b < 8; b++)
            sched(cyc + LAT + b, base + 2 * b, b, mem_m[widx(base + 2 * b)]);
          busy_until = cyc + 7;
        end else begin
          sched(cyc + LAT, (int'(bus.req_addr) / 2) * 2, 0, mem_m[widx(bus.req_addr)]);
        end
      end
      rst_prev = rst;
      @(posedge clk);
      #1;
      cyc++;
      if (armed) begin
        slot = cyc % 64;
        check("rsp_valid", bus.rsp_valid, ev[slot]);
        if (ev[slot]) begin
          check("rsp_data", bus.rsp_data, ed[slot]);
          check("rsp_addr", bus.rsp_addr, ea[slot]);
          check("rsp_word", bus.rsp_word, ew[slot]);
        end
        if (rst_prev) begin
          check("post_rst_data", bus.rsp_data, 0);
          check("post_rst_addr", bus.rsp_addr, 0);
          check("post_rst_word", bus.rsp_word, 0);
        end
        ev[slot] = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One request held across exactly one rising edge.
  task automatic cyc_req(input bit wr, input bit burst, input logic [15:0] addr,
                         input logic [15:0] wdata);
    @(negedge clk);
    bus.req_en    = 1'b1;
    bus.req_wr    = wr;
    bus.req_burst = burst;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clk);
    #1;
    bus.req_en    = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_burst = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst           = 1'b1;
    bus.req_en    = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_burst = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    wait_cycles(3);
    check("reset_valid", bus.rsp_valid, 0);
    check("reset_data",  bus.rsp_data, 0);
    check("reset_addr",  bus.rsp_addr, 0);
    check("reset_word",  bus.rsp_word, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_ready", bus.req_ready, 1);

    // Fill every word so all later reads return defined data.
    for (int i = 0; i < WORDS; i++) cyc_req(1'b1, 1'b0, 16'(2 * i), 16'($urandom));

    // Write then read back; response exactly LAT cycles after the read.
    cyc_req(1'b1, 1'b0, 16'h0010, 16'hBEEF);
    cyc_req(1'b0, 1'b0, 16'h0010, 16'h0);
    wait_cycles(LAT - 2);
    check("beef_early", bus.rsp_valid, 0);
    wait_cycles(1);
    check("beef_valid", bus.rsp_valid, 1);
    check("beef_data",  bus.rsp_data, 16'hBEEF);
    check("beef_addr",  bus.rsp_addr, 16'h0010);
    wait_cycles(LAT);

    // Three back-to-back reads come back on consecutive cycles in order.
    cyc_req(1'b0, 1'b0, 16'h0000, 16'h0);
    cyc_req(1'b0, 1'b0, 16'h0002, 16'h0);
    cyc_req(1'b0, 1'b0, 16'h0004, 16'h0);
    for (int k = 0; k < 3; k++) begin
      wait_cycles(1);
      check("b2b_valid", bus.rsp_valid, 1);
      check("b2b_addr",  bus.rsp_addr, 32'(2 * k));
    end
    wait_cycles(LAT);

    // A write after a read must not disturb the in-flight data.
    cyc_req(1'b1, 1'b0, 16'h0020, 16'h5555);
    cyc_req(1'b0, 1'b0, 16'h0020, 16'h0);
    cyc_req(1'b1, 1'b0, 16'h0020, 16'h1111);
    wait_cycles(LAT - 2);
    check("raw_old_data", bus.rsp_data, 16'h5555);
    cyc_req(1'b0, 1'b0, 16'h0020, 16'h0);
    wait_cycles(LAT - 1);
    check("raw_new_data", bus.rsp_data, 16'h1111);
    wait_cycles(LAT);

    // Address wrap (byte 0x212 aliases 0x012) and ignored bit 0.
    cyc_req(1'b1, 1'b0, 16'h0212, 16'h7E57);
    cyc_req(1'b0, 1'b0, 16'h0013, 16'h0);
    wait_cycles(LAT - 1);
    check("wrap_data", bus.rsp_data, 16'h7E57);
    check("wrap_addr", bus.rsp_addr, 16'h0012);
    wait_cycles(LAT);

    // Storage survives reset.
    cyc_req(1'b1, 1'b0, 16'h0000, 16'hAAAA);
    cyc_req(1'b0, 1'b0, 16'h0000, 16'h0);
    wait_cycles(LAT - 1);
    check("keep_before", bus.rsp_data, 16'hAAAA);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyc_req(1'b0, 1'b0, 16'h0000, 16'h0);
    wait_cycles(LAT - 1);
    check("keep_after", bus.rsp_data, 16'hAAAA);
    wait_cycles(LAT);

`ifdef MEM_RESPONDER_BURST_EN
    // Block read at 0x0046: ready low 7 cycles, beats 0x40..0x4E.
    cyc_req(1'b0, 1'b1, 16'h0046, 16'h0);
    for (int k = 1; k <= LAT + 8; k++) begin
      if (k <= 7) check("burst_busy", bus.req_ready, 0);
      else if (k == 8) check("burst_ready", bus.req_ready, 1);
      if (k >= LAT && k < LAT + 8) begin
        check("burst_valid", bus.rsp_valid, 1);
        check("burst_addr",  bus.rsp_addr, 32'(16'h0040 + 2 * (k - LAT)));
        check("burst_word",  bus.rsp_word, 32'(k - LAT));
      end else begin
        check("burst_quiet", bus.rsp_valid, 0);
      end
      wait_cycles(1);
    end

    // Reset on the cycle beat 3 issues: nothing may come out afterwards.
    cyc_req(1'b0, 1'b1, 16'h0080, 16'h0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_ready", bus.req_ready, 1);
    check("abort_valid0", bus.rsp_valid, 0);
    for (int k = 0; k < 12; k++) begin
      wait_cycles(1);
      check("abort_valid", bus.rsp_valid, 0);
    end
`else
    // Without the burst feature req_burst is ignored: single read, ready stays high.
    cyc_req(1'b0, 1'b1, 16'h0046, 16'h0);
    check("noburst_ready", bus.req_ready, 1);
    wait_cycles(LAT - 1);
    check("noburst_valid", bus.rsp_valid, 1);
    check("noburst_addr",  bus.rsp_addr, 16'h0046);
    check("noburst_word",  bus.rsp_word, 0);
    wait_cycles(1);
    check("noburst_single", bus.rsp_valid, 0);
`endif
    wait_cycles(LAT + 2);

    // Randomized traffic, including requests while busy and rare resets.
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      rst           = ($urandom_range(0, 149) == 0);
      bus.req_en    = ($urandom_range(0, 9) < 7);
      bus.req_wr    = ($urandom_range(0, 9) < 4);
      bus.req_burst = ($urandom_range(0, 9) < 2);
      bus.req_addr  = 16'($urandom);
      bus.req_wdata = 16'($urandom);
      @(posedge clk);
      #1;
    end
    rst           = 1'b0;
    bus.req_en    = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_burst = 1'b0;
    wait_cycles(LAT + 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
